// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes an ALU opcode into an 8-bit ALU control word and
// issues it with its operands through a valid/ready register stage.
// Bit 0 is the MSB of every vector here (operands and out_ac alike).
// Build option: define ALU_OP_ISSUE_SKID_EN for a two-entry skid buffer
// with a registered in_ready; default is a single output register.

`ifndef WORD_LENGTH
`define WORD_LENGTH 16
`endif

module alu_op_issue #(
    parameter int unsigned WIDTH = `WORD_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [1:0]       in_sa,
    input  logic             in_cin,
    input  logic [0:WIDTH-1] in_a,
    input  logic [0:WIDTH-1] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_a,
    output logic [0:WIDTH-1] out_b,
    output logic [0:7]       out_ac,
    output logic             out_err
);

    // Stored entry layout: {err, ac[0:7], a, b}
    localparam int unsigned ACW = 8;
    localparam int unsigned EW  = 2 * WIDTH + ACW + 1;

    logic [0:7]    dec_ac;
    logic          dec_err;
    logic [EW-1:0] dec_entry;
    logic [EW-1:0] out_q;
    logic          accept;
    logic          drain;

    // Opcode decode: ac = {cin, invert B, invert result, shift[2], alu op[3]}
    always_comb begin
        dec_ac  = 8'b0000_0000;
        dec_err = 1'b0;
        case (in_op)
            4'd0:    dec_ac = 8'b0000_0000;
            4'd1:    dec_ac = 8'b0010_0000;
            4'd2:    dec_ac = {3'b000, in_sa, 3'b001};
            4'd3:    dec_ac = 8'b0000_0010;
            4'd4:    dec_ac = {3'b000, in_sa, 3'b011};
            4'd5:    dec_ac = {in_cin, 2'b00, in_sa, 3'b011};
            4'd6:    dec_ac = {3'b110, in_sa, 3'b011};
            4'd7:    dec_ac = {in_cin, 2'b10, in_sa, 3'b011};
            4'd8:    dec_ac = 8'b0000_0101;
            4'd9:    dec_ac = 8'b0100_0101;
            4'd10:   dec_ac = 8'b0000_0110;
            4'd11:   dec_ac = 8'b0000_0111;
            4'd12:   dec_ac = 8'b0010_0101;
            4'd13:   dec_ac = 8'b0010_0110;
            4'd14:   dec_ac = 8'b0010_0111;
            default: begin
                dec_ac  = 8'b0000_0000;
                dec_err = 1'b1;
            end
        endcase
    end

    assign dec_entry = {dec_err, dec_ac, in_a, in_b};

    assign out_err = out_q[EW-1];
    assign out_ac  = out_q[EW-2 -: ACW];
    assign out_a   = out_q[2*WIDTH-1 -: WIDTH];
    assign out_b   = out_q[WIDTH-1:0];

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

`ifdef ALU_OP_ISSUE_SKID_EN

    logic [EW-1:0] skid_q;
    logic          skid_v;
    logic          rdy_q;

    assign in_ready = rdy_q;

    // Output register backed by one skid entry; in_ready tracks skid-empty
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            skid_v    <= 1'b0;
            skid_q    <= '0;
            rdy_q     <= 1'b0;
        end else if (skid_v) begin
            if (drain) begin
                out_q  <= skid_q;
                skid_v <= 1'b0;
                rdy_q  <= 1'b1;
            end
        end else if (accept) begin
            if (!out_valid || drain) begin
                out_q     <= dec_entry;
                out_valid <= 1'b1;
                rdy_q     <= 1'b1;
            end else begin
                skid_q <= dec_entry;
                skid_v <= 1'b1;
                rdy_q  <= 1'b0;
            end
        end else begin
            if (drain) begin
                out_valid <= 1'b0;
            end
            rdy_q <= 1'b1;
        end
    end

`else

    logic live_q;

    // live_q keeps in_ready low for the cycle following a reset edge
    assign in_ready = live_q & (~out_valid | out_ready);

    // Single output register, reloaded on accept, emptied on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q    <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                out_q     <= dec_entry;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized and directed bench for alu_op_issue against a queue model.
module tb_alu_op_issue;

    localparam int unsigned W = 16;
`ifdef ALU_OP_ISSUE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_op;
    logic [1:0]     in_sa;
    logic           in_cin;
    logic [0:W-1]   in_a;
    logic [0:W-1]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [0:W-1]   out_a;
    logic [0:W-1]   out_b;
    logic [0:7]     out_ac;
    logic           out_err;

    always #5 clk = ~clk;

    alu_op_issue #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sa(in_sa), .in_cin(in_cin),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ac(out_ac), .out_err(out_err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [7:0]   ac;
        logic         err;
    } ent_t;

    ent_t        q[$];
    bit          live;
    int          total;
    int          bad;
    int          drains;
    bit          prev_stall;
    logic [63:0] snap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word from the op table fields; value read with bit 0 as MSB
    function automatic logic [7:0] ref_ac(input int op, input int sa, input int cin);
        int alu_of[16] = '{0, 0, 1, 2, 3, 3, 3, 3, 5, 5, 6, 7, 5, 6, 7, 0};
        int c_f, ib, ir, sh;
        c_f = (op == 5 || op == 7) ? cin : ((op == 6) ? 1 : 0);
        ib  = (op == 6 || op == 7 || op == 9) ? 1 : 0;
        ir  = (op == 1 || op == 12 || op == 13 || op == 14) ? 1 : 0;
        sh  = (op == 2 || (op >= 4 && op <= 7)) ? sa : 0;
        return 8'(c_f * 128 + ib * 64 + ir * 32 + sh * 8 + alu_of[op]);
    endfunction

    function automatic bit exp_ready(input bit ordy);
        if (!live) return 1'b0;
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    // One clock: drive, check at negedge, advance model after the edge
    task automatic cycle(input logic v, input logic [3:0] op, input logic [1:0] sa,
                         input logic c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, output bit acc);
        bit   drn;
        ent_t e;
        in_valid = v; in_op = op; in_sa = sa; in_cin = c;
        in_a = a; in_b = b; out_ready = ordy;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(exp_ready(ordy)));
        if (q.size() > 0) begin
            chk("out_a", 64'(out_a), 64'(q[0].a));
            chk("out_b", 64'(out_b), 64'(q[0].b));
            chk("out_ac", 64'(out_ac), 64'(q[0].ac));
            chk("out_err", 64'(out_err), 64'(q[0].err));
        end
        if (prev_stall)
            chk("hold", 64'({out_a, out_b, out_ac, out_err}), snap);
        acc = v && exp_ready(ordy);
        drn = (q.size() > 0) && ordy;
        prev_stall = (q.size() > 0) && !ordy && !rst;
        snap = 64'({out_a, out_b, out_ac, out_err});
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            live = 1'b0;
            prev_stall = 1'b0;
            acc = 1'b0;
        end else begin
            live = 1'b1;
            if (drn) begin
                void'(q.pop_front());
                drains++;
            end
            if (acc) begin
                e.a = a; e.b = b; e.err = (op == 4'd15);
                e.ac = ref_ac(int'(op), int'(sa), int'(c));
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        cycle(1'b0, 4'd0, 2'd0, 1'b0, '0, '0, ordy, acc);
    endtask

    initial begin
        bit acc;
        int sent, guard;
        total = 0; bad = 0; drains = 0; prev_stall = 1'b0; snap = '0; live = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_sa = '0; in_cin = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_ac", 64'(out_ac), 64'd0);
        chk("rst_out_ab", 64'({out_a, out_b}), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        rst = 1'b0;
        idle(1'b1);
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed decode checks with literal expectations
        cycle(1'b1, 4'd4, 2'd2, 1'b0, 16'h0010, 16'h0003, 1'b1, acc);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_ac", 64'(out_ac), 64'(8'b0001_0011));
        chk("add_a", 64'(out_a), 64'h10);
        chk("add_b", 64'(out_b), 64'h3);
        chk("add_err", 64'(out_err), 64'd0);
        cycle(1'b1, 4'd5, 2'd1, 1'b1, 16'h1234, 16'h5678, 1'b1, acc);
        chk("adc_ac", 64'(out_ac), 64'(8'b1000_1011));
        cycle(1'b1, 4'd7, 2'd1, 1'b1, 16'h1111, 16'h2222, 1'b1, acc);
        chk("sbc_ac", 64'(out_ac), 64'(8'b1100_1011));
        cycle(1'b1, 4'd9, 2'd3, 1'b1, 16'h3333, 16'h4444, 1'b1, acc);
        chk("cand_ac", 64'(out_ac), 64'(8'b0100_0101));
        cycle(1'b1, 4'd15, 2'd3, 1'b1, 16'hdead, 16'hbeef, 1'b1, acc);
        chk("ill_ac", 64'(out_ac), 64'd0);
        chk("ill_err", 64'(out_err), 64'd1);
        cycle(1'b1, 4'd8, 2'd2, 1'b1, 16'h0f0f, 16'hf0f0, 1'b1, acc);
        chk("and_err", 64'(out_err), 64'd0);
        chk("and_ac", 64'(out_ac), 64'(8'b0000_0101));
        idle(1'b1);

        // Eight requests under a stalling consumer
        sent = 0; guard = 0;
        while ((sent < 8 || q.size() > 0) && guard < 300) begin
            logic v, r;
            v = (sent < 8) && ($urandom_range(0, 3) != 0);
            case (guard)
                0: r = 1'b1;
                1: r = 1'b0;
                2: r = 1'b0;
                3: r = 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            cycle(v, 4'($urandom), 2'($urandom), 1'($urandom), W'($urandom), W'($urandom), r, acc);
            if (acc) sent++;
            guard++;
        end
        chk("stream_done", 64'(guard < 300), 64'd1);

        // Sustained throughput with a ready consumer
        drains = 0; sent = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'($urandom), 2'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'b1, acc);
            if (acc) sent++;
        end
        chk("burst_accepts", 64'(sent), 64'd16);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            idle(1'b1);
            guard++;
        end
        chk("burst_xfers", 64'(drains), 64'd16);

        // Reset while entries are held stalled
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 4'($urandom), 2'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'b0, acc);
        chk("held_before_rst", 64'(q.size()), SKID ? 64'd2 : 64'd1);
        rst = 1'b1;
        cycle(1'b1, 4'd4, 2'd1, 1'b0, 16'haaaa, 16'h5555, 1'b1, acc);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_data", 64'({out_a, out_b, out_ac, out_err}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Long random run
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom), 1'($urandom_range(0, 2) != 0), acc);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            idle(1'b1);
            guard++;
        end
        chk("final_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 Parameter WIDTH, default `WORD_LENGTH, operand width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 in_op  input  4  operation code, table in REQ-012.
REQ-007 in_sa  input  2  A-operand left-shift amount, 0..3.
REQ-008 in_cin  input  1  carry flag for ADC/SBC.
REQ-009 in_a, in_b  input  WIDTH each  operands, bit 0 = MSB.
REQ-010 out_valid  output  1; out_ready  input  1; out_a, out_b  output  WIDTH; out_ac  output  8 (ALU control code, bit0 cin, bit1 invert B, bit2 invert result, bits3..4 shift A, bits5..7 ALU op); out_err  output  1 (illegal op).

Function
REQ-011 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-012 out_ac per in_op, bits 0..7 (ss = in_sa, c = in_cin): 0 ZERO 00000000; 1 ONES 00100000; 2 PASSA 000ss001; 3 PASSB 00000010; 4 ADD 000ss011; 5 ADC c00ss011; 6 SUB 100ss011 with bit1=1, i.e. 110ss011; 7 SBC c10ss011; 8 AND 00000101; 9 CAND 01000101; 10 OR 00000110; 11 XOR 00000111; 12 NAND 00100101; 13 NOR 00100110; 14 XNOR 00100111; 15 illegal.
REQ-013 in_sa ignored (shift field 00) for ops other than 2, 4, 5, 6, 7; in_cin ignored for ops other than 5, 7.
REQ-014 Op 15: out_ac = 00000000, out_err = 1 with that entry; entry still flows and is consumed normally; out_err = 0 for all other ops.
REQ-015 out_a, out_b = accepted in_a, in_b, unmodified; all out_* fields registered together, one entry.
REQ-016 Latency: request accepted at edge N appears on out_* with out_valid = 1 after edge N (cycle N+1); no combinational path from in_* data to out_*.
REQ-017 While out_valid = 1 and out_ready = 0, out_* held stable, bit-exact, until transfer.
REQ-018 Throughput: one transfer per cycle sustained when out_ready held 1.
REQ-019 Simultaneous accept and drain at same edge: drained entry replaced by new entry, out_valid stays 1, no bubble, no loss, no duplication.
REQ-020 Order preserved: entries leave in acceptance order.
REQ-021 in_valid may drop without transfer; in_* sampled only on accepting edge.

Reset
REQ-022 rst = 1 at an edge: out_valid = 0, in_ready = 0 during reset cycle, out_ac = 0, out_a = 0, out_b = 0, out_err = 0, all buffered entries discarded.
REQ-023 First edge with rst = 0: in_ready = 1 thereafter (empty state).
REQ-024 Reset mid-transfer overrides any concurrent accept or drain; accepted entry in that cycle is lost.

Configuration
REQ-025 Macro ALU_OP_ISSUE_SKID_EN defined: two-entry storage (output register + skid register); in_ready is a registered signal = skid register empty; upstream stall visible only one cycle after out_ready drops; at most one extra entry held.
REQ-026 Macro undefined: single output register; in_ready = ~out_valid | out_ready (combinational from out_ready); no skid storage.
REQ-027 REQ-011..REQ-021 hold identically in both configurations.

Verification
REQ-028 Reset, then in_op=4, in_sa=2, in_a=0x10, in_b=0x3, out_ready=1 -> next cycle out_valid=1, out_ac=00010011, out_a=0x10, out_b=0x3, out_err=0.
REQ-029 Ops 5 and 7 with in_cin=1, in_sa=1 -> out_ac=10001011 and 11001011; op 9 with in_sa=3 -> out_ac=01000101 (shift ignored).
REQ-030 in_op=15 -> out_ac=00000000, out_err=1; following op 8 -> out_err=0, out_ac=00000101.
REQ-031 Stream 8 requests, out_ready toggling 1,0,0,1,... random -> all 8 received in order, none dropped/duplicated, out_* stable while stalled; with SKID_EN in_ready drops exactly one cycle after first stall.
REQ-032 out_ready=1, in_valid=1 every cycle for 16 cycles -> 16 transfers, out_valid continuous after first.
REQ-033 Assert rst while entry held stalled (and skid full if enabled) -> next cycle out_valid=0, all outputs 0, held entries never emitted.
